// File: rtl/cache_arbiter_if.sv
// Bus bundle between the I-cache, the D-cache, the cache arbiter and the
// cacheline adaptor. s_line is the line width, s_addr the address width.
// The master modport is the arbiter's view; slave is the caches/adaptor view.
interface cache_arbiter_if #(
  parameter int s_line = 256,
  parameter int s_addr = 32
);
  // I-cache side
  logic              i_read;
  logic [s_addr-1:0] i_address;
  logic [s_line-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [s_addr-1:0] d_address;
  logic [s_line-1:0] d_wdata;
  logic [s_line-1:0] d_rdata;
  logic              d_resp;
  // Adaptor side
  logic              pmem_read;
  logic              pmem_write;
  logic [s_addr-1:0] pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;
  // Ownership flag for performance counters
  logic              arbiter_data_state;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata,
           arbiter_data_state
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata,
           arbiter_data_state
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical-memory port between the I-cache
// and the D-cache. One requester is granted at a time and keeps the port until
// pmem_resp; a single RELEASE cycle follows so the served cache can drop its
// request before the next arbitration.
// Optional feature macro ARB_RR_EN: when defined, simultaneous requests are
// granted to the side that was not served last; otherwise the D-cache always
// wins. Line/address widths come from the cache_arbiter_if parameters.
module cache_arbiter (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RELEASE} state_t;

  state_t state;
  logic   d_req;
  logic   grant_d;

`ifdef ARB_RR_EN
  typedef enum logic {GNT_I, GNT_D} grant_t;
  grant_t last_grant;
`endif

  assign d_req = bus.d_read | bus.d_write;

  // Arbitration decision used when leaving IDLE
  always_comb begin
    grant_d = d_req;
`ifdef ARB_RR_EN
    // On contention the side that was not served last wins
    if (d_req && bus.i_read) grant_d = (last_grant == GNT_I);
`endif
  end

  // Grant FSM; pmem command and ownership flag are registered so requests
  // never reach pmem_read/pmem_write combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      bus.pmem_read          <= 1'b0;
      bus.pmem_write         <= 1'b0;
      bus.arbiter_data_state <= 1'b0;
`ifdef ARB_RR_EN
      last_grant             <= GNT_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state                  <= D_BUSY;
            // A write-back wins if both strobes are (illegally) high
            bus.pmem_write         <= bus.d_write;
            bus.pmem_read          <= bus.d_read & ~bus.d_write;
            bus.arbiter_data_state <= 1'b1;
          end else if (bus.i_read) begin
            state         <= I_BUSY;
            bus.pmem_read <= 1'b1;
          end
        end
        I_BUSY: begin
          if (bus.pmem_resp) begin
            state         <= RELEASE;
            bus.pmem_read <= 1'b0;
`ifdef ARB_RR_EN
            last_grant    <= GNT_I;
`endif
          end
        end
        D_BUSY: begin
          if (bus.pmem_resp) begin
            state                  <= RELEASE;
            bus.pmem_read          <= 1'b0;
            bus.pmem_write         <= 1'b0;
            bus.arbiter_data_state <= 1'b0;
`ifdef ARB_RR_EN
            last_grant             <= GNT_D;
`endif
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Route the granted side's address/data and forward resp only to it
  always_comb begin
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.i_resp       = 1'b0;
    bus.d_resp       = 1'b0;
    case (state)
      I_BUSY: begin
        bus.pmem_address = bus.i_address;
        bus.i_resp       = bus.pmem_resp;
      end
      D_BUSY: begin
        bus.pmem_address = bus.d_address;
        bus.pmem_wdata   = bus.d_wdata;
        bus.d_resp       = bus.pmem_resp;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the resp strobe qualifies it
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

  // The D-cache must never read and write-back at the same time
  a_no_dual_d_req : assert property (@(posedge clk) disable iff (rst)
    !(bus.d_read && bus.d_write))
    else $error("cache_arbiter: d_read and d_write asserted together");

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a scoreboard of expected transactions is
// filled when requests are driven and drained whenever a resp is observed.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if #(.s_line(256), .s_addr(32)) bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    bit           side;   // 0 = I-cache, 1 = D-cache
    logic [31:0]  addr;
    bit           wr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_iresp  = 0;
  int   n_dresp  = 0;
  int   exp_i    = 0;
  int   exp_d    = 0;
  bit   last_d   = 1'b0;  // model of the arbiter's last served side

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %064h expected %064h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void expect_i(input logic [31:0] a, input logic [255:0] rd);
    exp_t e;
    e.side = 1'b0; e.addr = a; e.wr = 1'b0; e.wdata = '0; e.rdata = rd;
    sb.push_back(e);
    exp_i++;
    last_d = 1'b0;
  endfunction

  function automatic void expect_d(input logic [31:0] a, input bit wr,
                                   input logic [255:0] wd, input logic [255:0] rd);
    exp_t e;
    e.side = 1'b1; e.addr = a; e.wr = wr; e.wdata = wd; e.rdata = rd;
    sb.push_back(e);
    exp_d++;
    last_d = 1'b1;
  endfunction

  // Every output except the rdata broadcast must be zero
  task automatic quiet(input string tag);
    chk1({tag, "_ctl"}, |{bus.pmem_read, bus.pmem_write, bus.i_resp,
                          bus.d_resp, bus.arbiter_data_state}, 1'b0);
    chka({tag, "_addr"}, bus.pmem_address, 32'h0);
    chkw({tag, "_wdata"}, bus.pmem_wdata, '0);
  endtask

  // Adaptor model: wait (bounded) for a command, answer after lat cycles with
  // rd, then let whichever cache got its resp drop its request.
  task automatic serve(input int lat, input logic [255:0] rd);
    int w;
    bit gi, gd;
    w = 0;
    @(negedge clk);
    while (!(bus.pmem_read || bus.pmem_write) && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk1("grant_seen", bus.pmem_read | bus.pmem_write, 1'b1);
    repeat (lat - 1) @(posedge clk);
    #1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rd;
    @(negedge clk);
    gi = bus.i_resp;
    gd = bus.d_resp;
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
    if (gi) bus.i_read = 1'b0;
    if (gd) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end
  endtask

  // Scoreboard drain: every resp must match the oldest expected transaction
  always @(negedge clk) begin
    if (bus.i_resp || bus.d_resp) begin
      chk1("resp_exclusive", bus.i_resp & bus.d_resp, 1'b0);
      chk1("resp_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk1("resp_side", bus.d_resp, mon_e.side);
        chka("resp_addr", bus.pmem_address, mon_e.addr);
        chk1("resp_write", bus.pmem_write, mon_e.wr);
        chkw("resp_wdata", bus.pmem_wdata, mon_e.wdata);
        chkw("resp_rdata", mon_e.side ? bus.d_rdata : bus.i_rdata, mon_e.rdata);
      end
      if (bus.i_resp) n_iresp++;
      if (bus.d_resp) n_dresp++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wb_line;
    logic [255:0] rnd;
    logic [255:0] rd_first, rd_second;
    bit           d_first;

    wb_line = {32{8'hA5}};
    rst = 1'b1;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and rdata broadcast
    @(negedge clk);
    quiet("reset");
    @(posedge clk);
    #1;
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.pmem_rdata = rnd;
    @(negedge clk);
    chkw("i_rdata_bcast", bus.i_rdata, rnd);
    chkw("d_rdata_bcast", bus.d_rdata, rnd);

    // Lone I read
    @(posedge clk);
    #1;
    bus.i_address = 32'h0000_0060;
    bus.i_read    = 1'b1;
    expect_i(32'h0000_0060, {8{32'hC0DE_0001}});
    @(negedge clk);
    chk1("i_no_comb_path", bus.pmem_read, 1'b0);
    @(negedge clk);
    chk1("i_pmem_read", bus.pmem_read, 1'b1);
    chk1("i_pmem_write", bus.pmem_write, 1'b0);
    chka("i_pmem_addr", bus.pmem_address, 32'h0000_0060);
    chk1("i_data_state", bus.arbiter_data_state, 1'b0);
    serve(4, {8{32'hC0DE_0001}});
    @(negedge clk);
    quiet("i_release");
    @(negedge clk);
    quiet("i_idle");

    // D write-back
    @(posedge clk);
    #1;
    bus.d_address = 32'h0000_1AE0;
    bus.d_wdata   = wb_line;
    bus.d_write   = 1'b1;
    expect_d(32'h0000_1AE0, 1'b1, wb_line, {8{32'hD00D_0002}});
    @(negedge clk);
    chk1("d_no_comb_path", bus.pmem_write, 1'b0);
    @(negedge clk);
    chk1("d_pmem_write", bus.pmem_write, 1'b1);
    chk1("d_pmem_read", bus.pmem_read, 1'b0);
    chka("d_pmem_addr", bus.pmem_address, 32'h0000_1AE0);
    chkw("d_pmem_wdata", bus.pmem_wdata, wb_line);
    chk1("d_data_state", bus.arbiter_data_state, 1'b1);
    serve(4, {8{32'hD00D_0002}});
    @(negedge clk);
    quiet("d_release");

    // Contention after a D transaction (fixed: D first; round-robin: I first)
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 1) begin
        // Make I the last served side, then contend again: D wins in both modes
        @(posedge clk);
        #1;
        bus.i_address = 32'h0000_0400;
        bus.i_read    = 1'b1;
        expect_i(32'h0000_0400, {8{32'h1111_0004}});
        serve(3, {8{32'h1111_0004}});
        @(negedge clk);
        quiet("pre_rep_release");
      end
`ifdef ARB_RR_EN
      d_first = !last_d;
`else
      d_first = 1'b1;
`endif
      @(posedge clk);
      #1;
      bus.i_address = 32'h0000_0100 + 32'(rep);
      bus.d_address = 32'h0000_0200 + 32'(rep);
      bus.i_read    = 1'b1;
      bus.d_read    = 1'b1;
      if (d_first) begin
        rd_first  = {8{32'hDDDD_0000 + 32'(rep)}};
        rd_second = {8{32'h1111_0000 + 32'(rep)}};
        expect_d(32'h0000_0200 + 32'(rep), 1'b0, wb_line, rd_first);
        expect_i(32'h0000_0100 + 32'(rep), rd_second);
      end else begin
        rd_first  = {8{32'h1111_0000 + 32'(rep)}};
        rd_second = {8{32'hDDDD_0000 + 32'(rep)}};
        expect_i(32'h0000_0100 + 32'(rep), rd_first);
        expect_d(32'h0000_0200 + 32'(rep), 1'b0, wb_line, rd_second);
      end
      @(negedge clk);
      @(negedge clk);
      chk1("cont_data_state", bus.arbiter_data_state, d_first);
      serve(3, rd_first);
      @(negedge clk);
      quiet("cont_release");
      serve(3, rd_second);
      @(negedge clk);
      quiet("cont_release2");
    end

    // Reset in the middle of a D read: abandoned, no resp, then fresh read
    @(posedge clk);
    #1;
    bus.d_address = 32'h0000_0300;
    bus.d_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_pre_grant", bus.arbiter_data_state, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.d_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    quiet("rst_mid");
    @(posedge clk);
    #1;
    bus.d_address = 32'h0000_0340;
    bus.d_read    = 1'b1;
    expect_d(32'h0000_0340, 1'b0, wb_line, {8{32'h5EED_0005}});
    @(negedge clk);
    chk1("rst_fresh_latency", bus.pmem_read, 1'b0);
    serve(3, {8{32'h5EED_0005}});
    @(negedge clk);
    quiet("rst_fresh_release");

    // Spurious pmem_resp in IDLE is ignored
    @(posedge clk);
    #1 bus.pmem_resp = 1'b1;
    @(negedge clk);
    quiet("spur_idle");
    @(posedge clk);
    #1 bus.pmem_resp = 1'b0;
    @(negedge clk);
    quiet("spur_after");
    @(posedge clk);
    #1;
    bus.i_address = 32'h0000_0800;
    bus.i_read    = 1'b1;
    expect_i(32'h0000_0800, {8{32'h0BAD_0006}});
    @(negedge clk);
    chk1("spur_no_grant_yet", bus.pmem_read, 1'b0);
    @(negedge clk);
    chk1("spur_grant_next", bus.pmem_read, 1'b1);
    serve(3, {8{32'h0BAD_0006}});
    @(negedge clk);
    quiet("spur_release");

    // Every expected transaction answered exactly once
    repeat (3) @(negedge clk);
    chkn("sb_drained", sb.size(), 0);
    chkn("i_resp_count", n_iresp, exp_i);
    chkn("d_resp_count", n_dresp, exp_d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
